// File: rtl/belfft_pkg.sv
// belfft_pkg: shared FSM type, control field widths and twiddle word layout
// for the twiddle fetch block.
package belfft_pkg;
    localparam int LOG2N_W = 4;
    localparam int STAGE_W = 4;
    // twiddle words are {real, imag}: the half index selects a WORD_WIDTH slice
    localparam int TW_RE_HALF = 1;
    localparam int TW_IM_HALF = 0;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;
endpackage

// File: rtl/belfft_tw_skid.sv
// belfft_tw_skid: two-entry valid/ready buffer between the twiddle ROM and the
// butterfly; the head entry drives the output so data holds while stalled.
module belfft_tw_skid #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         rdy,
    output logic         vld,
    output logic [W-1:0] dout,
    output logic [1:0]   cnt
);
    logic [W-1:0] d1;
    logic pop;
    assign vld = cnt != 2'd0;
    assign pop = vld & rdy;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= 2'd0;
            dout <= '0;
            d1   <= '0;
        end else if (flush) begin
            cnt <= 2'd0;
        end else begin
            if (pop && cnt == 2'd2)
                dout <= d1;
            if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop)))
                dout <= din;
            else if (push)
                d1 <= din;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/belfft_twiddle_fetch.sv
// belfft_twiddle_fetch: per-stage twiddle ROM address generator and fetch buffer.
// Define BELFFT_TW_CONJ_EN to conjugate twiddles when inv_i is sampled high.
module belfft_twiddle_fetch
    import belfft_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int MAX_AWIDTH = 6,
    parameter int CONFIG_NUM = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [LOG2N_W-1:0]      log2n_i,
    input  logic [STAGE_W-1:0]      stage_i,
    input  logic [CONFIG_NUM-1:0]   cfg_sel_i,
    input  logic                    inv_i,
    output logic [MAX_AWIDTH-1:0]   rom_adr_o,
    output logic                    rom_rd_o,
    input  logic [2*WORD_WIDTH-1:0] rom_dat_i,
    output logic [2*WORD_WIDTH-1:0] tw_dat_o,
    output logic                    tw_vld_o,
    input  logic                    tw_rdy_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);
    localparam int AW = MAX_AWIDTH;
    localparam logic [LOG2N_W-1:0] L_ONE = LOG2N_W'(1);
    state_t state;
    logic [AW-1:0] j_q, last_j, mask;
    logic [AW:0] unit;
    logic [LOG2N_W-1:0] log2n_q, sh;
    logic [STAGE_W-1:0] stage_q;
    logic inv_q, in_flight, legal, pop, rd;
    logic [1:0] cnt;
    logic [2:0] committed;
    logic [2*WORD_WIDTH-1:0] fetched;

    assign unit      = (AW+1)'(1);
    assign mask      = AW'((unit << stage_q) - unit);
    assign last_j    = AW'((unit << (log2n_q - L_ONE)) - unit);
    assign sh        = log2n_q - LOG2N_W'(stage_q) - L_ONE;
    assign rom_adr_o = (j_q & mask) << sh;
    assign legal     = (LOG2N_W'(stage_i) < log2n_i) && (log2n_i <= LOG2N_W'(AW + 1));
    assign pop       = tw_vld_o & tw_rdy_i;
    // a read is only issued when the buffer is sure to have room for its word
    assign committed = 3'(cnt) + 3'(in_flight) - 3'(pop);
    assign rd        = (state == ST_RUN) && (committed < 3'd2);
    assign rom_rd_o  = rd;
    assign busy_o    = state != ST_IDLE;

`ifdef BELFFT_TW_CONJ_EN
    localparam logic [WORD_WIDTH-1:0] IM_MIN = {1'b1, {(WORD_WIDTH-1){1'b0}}};
    logic [WORD_WIDTH-1:0] im, im_neg;
    logic unused_cfg;
    assign im         = rom_dat_i[TW_IM_HALF*WORD_WIDTH +: WORD_WIDTH];
    assign im_neg     = (im == IM_MIN) ? ~IM_MIN : -im;
    assign fetched    = inv_q ? {rom_dat_i[TW_RE_HALF*WORD_WIDTH +: WORD_WIDTH], im_neg} : rom_dat_i;
    assign unused_cfg = ^cfg_sel_i;
`else
    logic unused_cfg;
    assign fetched    = rom_dat_i;
    assign unused_cfg = ^{cfg_sel_i, inv_q};
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            j_q       <= '0;
            log2n_q   <= '0;
            stage_q   <= '0;
            inv_q     <= 1'b0;
            in_flight <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            in_flight <= rd;
            if (abort_i) begin
                state     <= ST_IDLE;
                j_q       <= '0;
                in_flight <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (start_i) begin
                        if (legal) begin
                            state   <= ST_RUN;
                            j_q     <= '0;
                            log2n_q <= log2n_i;
                            stage_q <= stage_i;
                            inv_q   <= inv_i;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                    ST_RUN: if (rd) begin
                        j_q <= (j_q == last_j) ? '0 : j_q + AW'(1);
                        if (j_q == last_j)
                            state <= ST_DRAIN;
                    end
                    ST_DRAIN: if (cnt == 2'd0 && !in_flight) begin
                        state  <= ST_IDLE;
                        done_o <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    belfft_tw_skid #(.W(2*WORD_WIDTH)) u_skid (
        .clk   (clk_i),
        .rst   (rst_i),
        .flush (abort_i),
        .push  (in_flight),
        .din   (fetched),
        .rdy   (tw_rdy_i),
        .vld   (tw_vld_o),
        .dout  (tw_dat_o),
        .cnt   (cnt)
    );
endmodule
